// File: rtl/pal_cfg_pkg.sv
// -----------------------------------------------------------------------------
// pal_cfg_pkg
// Shared definitions for the PAL configuration loader. The chain-length
// helpers live here so that the PAL top and the loader always agree on how
// many crosspoint bits exist for a given N/M/P.
//   cfg_state_e : loader sequencing states
//   sr_len()    : configuration chain length for N inputs, M outputs, P terms
//   nwords()    : host words needed to cover a chain of the given length
// -----------------------------------------------------------------------------
package pal_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } cfg_state_e;

    // AND plane holds true and complement literals (2*N per term),
    // OR plane holds one crosspoint per term per output.
    function automatic int sr_len(input int n, input int m, input int p);
        return 2 * n * p + p * m;
    endfunction

    function automatic int nwords(input int srLen, input int w);
        return (srLen + w - 1) / w;
    endfunction

endpackage

// File: rtl/pal_cfg_piso.sv
// -----------------------------------------------------------------------------
// pal_cfg_piso
// W-bit parallel-load, MSB-first shift buffer feeding the configuration chain.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears the buffer
//   clear_i : synchronous clear, highest priority
//   load_i  : capture data_i
//   shift_i : shift left by one, zero fill
//   data_i  : parallel word
//   sdata_o : buffer MSB (the bit currently presented to the chain)
// -----------------------------------------------------------------------------
module pal_cfg_piso #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         sdata_o
);

    logic [W-1:0] buf_q;
    logic [W-1:0] buf_d;

    // Clear wins so the serial output is forced low whenever the loader is
    // not shifting, which keeps the serial bit a plain flop output.
    always_comb begin
        buf_d = buf_q;
        if (clear_i) begin
            buf_d = '0;
        end else if (load_i) begin
            buf_d = data_i;
        end else if (shift_i) begin
            buf_d = buf_q << 1;
        end
    end

    // Buffer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign sdata_o = buf_q[W-1];

endmodule

// File: rtl/pal_cfg_loader.sv
// -----------------------------------------------------------------------------
// pal_cfg_loader
// Accepts configuration words from a host over valid/ready and serialises
// them MSB-first into the PAL configuration shift chain, stopping exactly at
// SR_LEN bits. Keeps a running XOR of accepted words for host readback.
//   CLK        : clock, rising edge
//   RES_N      : asynchronous active-low reset
//   START      : single-cycle request to begin a load (ignored while busy)
//   ABORT      : cancel a load in progress; beats START and the handshake
//   DIN        : host configuration word
//   DIN_VALID  : DIN is valid
//   DIN_READY  : loader accepts DIN this cycle
//   CFG_DATA   : serial bit to the chain input, 0 when not shifting
//   CFG_SHIFT  : chain shift enable
//   BUSY       : load in progress
//   CFG_LOADED : the full chain has been written
//   CHECKSUM   : XOR of words accepted in the current or last load
// -----------------------------------------------------------------------------
module pal_cfg_loader
    import pal_cfg_pkg::*;
#(
    parameter  int N      = 8,
    parameter  int M      = 8,
    parameter  int P      = 8,
    parameter  int W      = 8,
    localparam int SR_LEN = sr_len(N, M, P),
    localparam int NWORDS = nwords(SR_LEN, W)
) (
    input  logic         CLK,
    input  logic         RES_N,
    input  logic         START,
    input  logic         ABORT,
    input  logic [W-1:0] DIN,
    input  logic         DIN_VALID,
    output logic         DIN_READY,
    output logic         CFG_DATA,
    output logic         CFG_SHIFT,
    output logic         BUSY,
    output logic         CFG_LOADED,
    output logic [W-1:0] CHECKSUM
);

    localparam int CW        = $clog2(SR_LEN + 1);
    localparam int WCW       = $clog2(W + 1);
    localparam int LAST_BITS = SR_LEN - (NWORDS - 1) * W;

    cfg_state_e     state_q, state_d;
    logic           busy_q, busy_d;
    logic           loaded_q, loaded_d;
    logic           ready_q;
    logic           shift_q;
    logic [W-1:0]   chk_q, chk_d;
    logic [CW-1:0]  bitCnt_q, bitCnt_d;
    logic [WCW-1:0] wordBit_q, wordBit_d;
    logic           accept;
    logic           lastWord;
    logic [WCW-1:0] lastIdx;

    // The final word may be short; once the bit counter has passed all full
    // words, only the remaining LAST_BITS are shifted.
    assign lastWord = (bitCnt_q >= CW'((NWORDS - 1) * W));
    assign lastIdx  = lastWord ? WCW'(LAST_BITS - 1) : WCW'(W - 1);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        loaded_d  = loaded_q;
        chk_d     = chk_q;
        bitCnt_d  = bitCnt_q;
        wordBit_d = wordBit_q;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    state_d  = LOAD;
                    busy_d   = 1'b1;
                    loaded_d = 1'b0;
                    chk_d    = '0;
                    bitCnt_d = '0;
                end
            end
            LOAD: begin
                if (DIN_VALID && ready_q) begin
                    accept    = 1'b1;
                    chk_d     = chk_q ^ DIN;
                    wordBit_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bitCnt_d  = bitCnt_q + 1'b1;
                wordBit_d = wordBit_q + 1'b1;
                if (wordBit_q == lastIdx) begin
                    state_d = (bitCnt_q == CW'(SR_LEN - 1)) ? DONE : LOAD;
                end
            end
            DONE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                loaded_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything above, including a same-cycle handshake.
        if (ABORT && (state_q != IDLE)) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            loaded_d  = 1'b0;
            chk_d     = chk_q;
            bitCnt_d  = bitCnt_q;
            wordBit_d = wordBit_q;
            accept    = 1'b0;
        end
    end

    // State, counters and registered outputs. Ready and shift enable are
    // decoded from the next state so they line up with the state register.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            loaded_q  <= 1'b0;
            ready_q   <= 1'b0;
            shift_q   <= 1'b0;
            chk_q     <= '0;
            bitCnt_q  <= '0;
            wordBit_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            loaded_q  <= loaded_d;
            ready_q   <= (state_d == LOAD);
            shift_q   <= (state_d == SHIFT);
            chk_q     <= chk_d;
            bitCnt_q  <= bitCnt_d;
            wordBit_q <= wordBit_d;
        end
    end

    pal_cfg_piso #(
        .W(W)
    ) u_piso (
        .clk_i   (CLK),
        .rst_ni  (RES_N),
        .clear_i (state_d != SHIFT),
        .load_i  (accept),
        .shift_i (state_q == SHIFT),
        .data_i  (DIN),
        .sdata_o (CFG_DATA)
    );

    assign DIN_READY  = ready_q;
    assign CFG_SHIFT  = shift_q;
    assign BUSY       = busy_q;
    assign CFG_LOADED = loaded_q;
    assign CHECKSUM   = chk_q;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_pal_cfg_loader
// Bench for the PAL configuration loader. Two instances share the stimulus:
// dutA uses the default geometry (192-bit chain), dutB a 21-bit chain so the
// short final word is exercised. 'sel' picks which instance is observed.
// Expected chain bits are queued as each word is accepted and popped as the
// DUT shifts them out.
// -----------------------------------------------------------------------------
module tb_pal_cfg_loader;

    logic       CLK       = 1'b0;
    logic       RES_N     = 1'b0;
    logic       START     = 1'b0;
    logic       ABORT     = 1'b0;
    logic [7:0] DIN       = 8'h00;
    logic       DIN_VALID = 1'b0;

    logic       aReady, aData, aShift, aBusy, aLoaded;
    logic [7:0] aChk;
    logic       bReady, bData, bShift, bBusy, bLoaded;
    logic [7:0] bChk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int sel         = 0;
    int srLen       = 192;
    int shifts      = 0;
    int pushed      = 0;
    int nWords      = 24;
    int startCyc    = 0;
    int firstAcc    = 0;
    int loadedCyc   = 0;
    int total       = 0;

    logic [191:0] chain;
    logic [191:0] expChain;
    logic [7:0]   chkModel;
    logic [7:0]   words [24];
    bit           expQ [$];

    logic       oReady, oData, oShift, oBusy, oLoaded;
    logic [7:0] oChk;

    // Free-running clock.
    always #5 CLK = ~CLK;

    pal_cfg_loader dutA (
        .CLK        (CLK),
        .RES_N      (RES_N),
        .START      (START),
        .ABORT      (ABORT),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .DIN_READY  (aReady),
        .CFG_DATA   (aData),
        .CFG_SHIFT  (aShift),
        .BUSY       (aBusy),
        .CFG_LOADED (aLoaded),
        .CHECKSUM   (aChk)
    );

    pal_cfg_loader #(.N(3), .M(1), .P(3), .W(8)) dutB (
        .CLK        (CLK),
        .RES_N      (RES_N),
        .START      (START),
        .ABORT      (ABORT),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .DIN_READY  (bReady),
        .CFG_DATA   (bData),
        .CFG_SHIFT  (bShift),
        .BUSY       (bBusy),
        .CFG_LOADED (bLoaded),
        .CHECKSUM   (bChk)
    );

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (sel == 0) begin
            oReady = aReady; oData = aData; oShift = aShift;
            oBusy = aBusy; oLoaded = aLoaded; oChk = aChk;
        end else begin
            oReady = bReady; oData = bData; oShift = bShift;
            oBusy = bBusy; oLoaded = bLoaded; oChk = bChk;
        end
    endtask

    // One clock: sample mid-cycle, track the chain image and score shifted bits.
    task automatic step();
        bit e;
        @(negedge CLK);
        cyc++;
        sample();
        if (oShift) begin
            shifts++;
            chain = {chain[190:0], oData};
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("cfg_data", oData, e);
            end else begin
                checkOutput("extra_shift", oShift, 0);
            end
        end else begin
            checkOutput("data_not_shifting", oData, 0);
        end
    endtask

    // Offer a word; once ready is seen the next edge accepts it, so the
    // expected bits are queued now and DIN is held across that edge.
    task automatic applyStimulus(input logic [7:0] w);
        int n;
        DIN       = w;
        DIN_VALID = 1'b1;
        for (int i = 0; i < 40 && !oReady; i++) step();
        checkOutput("ready_timeout", oReady, 1);
        if (oReady) begin
            if (pushed == 0) firstAcc = cyc;
            n = (srLen - pushed < 8) ? srLen - pushed : 8;
            for (int b = 0; b < n; b++) expQ.push_back(w[7 - b]);
            pushed   += n;
            chkModel ^= w;
            step();
        end
    endtask

    task automatic beginLoad();
        expQ.delete();
        pushed   = 0;
        chkModel = 8'h00;
        shifts   = 0;
        chain    = '0;
        firstAcc = -1;
        startCyc = cyc;
        START    = 1'b1;
        step();
        START    = 1'b0;
        checkOutput("busy_after_start", oBusy, 1);
        checkOutput("chk_cleared", oChk, 0);
    endtask

    // Full load of words[0..nWords-1], optionally stalling before word
    // stallAt and pulsing START during the shift of word glitchAt.
    task automatic runLoad(input int stallAt, input int glitchAt, output int tot);
        beginLoad();
        for (int k = 0; k < nWords; k++) begin
            if (k == stallAt) begin
                DIN_VALID = 1'b0;
                for (int i = 0; i < 40 && !oReady; i++) step();
                for (int i = 0; i < 10; i++) begin
                    step();
                    checkOutput("stall_ready", oReady, 1);
                    checkOutput("stall_no_shift", oShift, 0);
                    checkOutput("stall_chk", oChk, chkModel);
                end
            end
            applyStimulus(words[k]);
            if (k == glitchAt) begin
                START = 1'b1;
                step();
                START = 1'b0;
            end
        end
        DIN_VALID = 1'b0;
        for (int i = 0; i < 40 && !oLoaded; i++) step();
        loadedCyc = cyc;
        checkOutput("loaded", oLoaded, 1);
        checkOutput("busy_done", oBusy, 0);
        checkOutput("shift_count", shifts, srLen);
        checkOutput("checksum_model", oChk, chkModel);
        checkOutput("queue_drained", expQ.size(), 0);
        tot = loadedCyc - startCyc;
    endtask

    initial begin
        for (int k = 0; k < 24; k++) words[k] = 8'(k + 1);
        expChain = '0;
        for (int k = 0; k < 24; k++) expChain = {expChain[183:0], words[k]};

        // Reset state.
        repeat (2) step();
        checkOutput("rst_ready", oReady, 0);
        checkOutput("rst_shift", oShift, 0);
        checkOutput("rst_data", oData, 0);
        checkOutput("rst_busy", oBusy, 0);
        checkOutput("rst_loaded", oLoaded, 0);
        checkOutput("rst_chk", oChk, 0);
        RES_N = 1'b1;
        step();

        // Default full load, DIN_VALID held high.
        runLoad(-1, -1, total);
        checkOutput("load_cycles", total, 218);
        checkOutput("accept_to_loaded", loadedCyc - firstAcc, 24 * 9 + 1);
        checkOutput("checksum_default", oChk, 8'h18);
        checkOutput("chain_bit191", chain[191], 0);
        checkOutput("chain_bit0", chain[0], 0);
        checkOutput("chain_image", 32'(chain == expChain), 1);

        // Ten-cycle stall in the second LOAD.
        runLoad(1, -1, total);
        checkOutput("stall_load_cycles", total, 228);
        checkOutput("stall_checksum", oChk, 8'h18);

        // ABORT together with a handshake: word is dropped.
        beginLoad();
        DIN       = 8'hFF;
        DIN_VALID = 1'b1;
        ABORT     = 1'b1;
        step();
        ABORT     = 1'b0;
        DIN_VALID = 1'b0;
        checkOutput("abort_hs_chk", oChk, 0);
        checkOutput("abort_hs_busy", oBusy, 0);
        checkOutput("abort_hs_ready", oReady, 0);
        checkOutput("abort_hs_shift", oShift, 0);

        // ABORT in the 5th shift cycle of word 3.
        beginLoad();
        applyStimulus(8'hA5);
        applyStimulus(8'h3C);
        applyStimulus(8'h0F);
        repeat (4) step();
        ABORT     = 1'b1;
        DIN_VALID = 1'b0;
        step();
        ABORT     = 1'b0;
        expQ.delete();
        checkOutput("abort_shift", oShift, 0);
        checkOutput("abort_busy", oBusy, 0);
        checkOutput("abort_loaded", oLoaded, 0);
        checkOutput("abort_data", oData, 0);
        checkOutput("abort_ready", oReady, 0);
        checkOutput("abort_partial_chk", oChk, 8'h96);
        repeat (3) step();
        checkOutput("abort_idle_shift", oShift, 0);

        // Clean reload after abort, with a START glitch mid-shift.
        runLoad(-1, 4, total);
        checkOutput("reload_cycles", total, 218);
        checkOutput("reload_checksum", oChk, 8'h18);
        checkOutput("reload_chain", 32'(chain == expChain), 1);

        // START with ABORT in IDLE stays idle and keeps the checksum.
        START = 1'b1;
        ABORT = 1'b1;
        step();
        START = 1'b0;
        ABORT = 1'b0;
        step();
        checkOutput("sa_busy", oBusy, 0);
        checkOutput("sa_ready", oReady, 0);
        checkOutput("sa_chk", oChk, 8'h18);
        checkOutput("sa_loaded", oLoaded, 1);

        // Reset pulse mid-SHIFT.
        beginLoad();
        applyStimulus(words[0]);
        step();
        RES_N = 1'b0;
        #1;
        sample();
        checkOutput("mid_rst_ready", oReady, 0);
        checkOutput("mid_rst_shift", oShift, 0);
        checkOutput("mid_rst_data", oData, 0);
        checkOutput("mid_rst_busy", oBusy, 0);
        checkOutput("mid_rst_loaded", oLoaded, 0);
        checkOutput("mid_rst_chk", oChk, 0);
        step();
        RES_N = 1'b1;
        DIN_VALID = 1'b0;
        expQ.delete();
        step();
        checkOutput("post_rst_ready", oReady, 0);
        checkOutput("post_rst_busy", oBusy, 0);
        beginLoad();
        checkOutput("post_rst_start_ready", oReady, 1);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;

        // Short chain: 21 bits, final word contributes its top 5 bits.
        RES_N = 1'b0;
        step();
        RES_N = 1'b1;
        step();
        sel      = 1;
        srLen    = 21;
        nWords   = 3;
        words[0] = 8'hFF;
        words[1] = 8'h00;
        words[2] = 8'hA8;
        runLoad(-1, -1, total);
        checkOutput("short_load_cycles", total, 26);
        checkOutput("short_checksum", oChk, 8'h57);
        checkOutput("short_chain", chain[20:0], 21'h1FE015);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
